// File: rtl/qvga_pkg.sv
// ---------------------------------------------------------------------------
// qvga_pkg
// Shared definitions for the QVGA camera capture block: default frame
// geometry, frame-buffer address width and the capture state encoding.
// ---------------------------------------------------------------------------
package qvga_pkg;

   localparam int H_RES_DEF = 320;   // active pixels per line
   localparam int V_RES_DEF = 240;   // active lines per frame
   localparam int ADDR_W    = 17;    // frame-buffer address width

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WAIT_VS = 2'd1,
      ACTIVE  = 2'd2
   } qvga_state_e;

endpackage

// File: rtl/rgb565_to_444.sv
// ---------------------------------------------------------------------------
// rgb565_to_444
// Assembles RGB565 byte pairs (high byte first) into RGB444 pixels.
//
// Ports
//   clk        pixel clock, rising edge
//   reset      asynchronous active-low reset
//   clr        synchronous clear of the byte phase (frame start, line end)
//   byte_en    a camera byte is present on cam_data this cycle
//   cam_data   camera byte
//   pix_valid  this cycle's byte completes a pixel
//   pix        RGB444 pixel {R[4:1], G[5:2], B[4:1]}, valid with pix_valid
// ---------------------------------------------------------------------------
module rgb565_to_444 (
   input  logic        clk,
   input  logic        reset,
   input  logic        clr,
   input  logic        byte_en,
   input  logic [7:0]  cam_data,
   output logic        pix_valid,
   output logic [11:0] pix
);

   logic       phase_q;
   logic       phase_d;
   // Only the high-byte bits that reach the pixel are kept: R[4:1] and G[5:3].
   logic [6:0] hi_q;
   logic [6:0] hi_d;

   // Next-state logic for the byte phase and the latched high byte.
   always_comb begin
      phase_d = phase_q;
      hi_d    = hi_q;
      if (clr) begin
         phase_d = 1'b0;
      end else if (byte_en) begin
         phase_d = ~phase_q;
         if (!phase_q) begin
            hi_d = {cam_data[7:4], cam_data[2:0]};
         end else begin
            hi_d = hi_q;
         end
      end else begin
         phase_d = phase_q;
      end
   end

   // Phase and high-byte registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         phase_q <= 1'b0;
         hi_q    <= 7'd0;
      end else begin
         phase_q <= phase_d;
         hi_q    <= hi_d;
      end
   end

   // The low byte is used straight off the bus so the pixel is ready in the
   // same cycle the second byte is sampled.
   assign pix_valid = byte_en & phase_q;
   assign pix       = {hi_q[6:3], hi_q[2:0], cam_data[7], cam_data[4:1]};

endmodule

// File: rtl/qvga_capture.sv
// ---------------------------------------------------------------------------
// qvga_capture
// Captures RGB565 camera frames (vsync/href protocol) and writes them as
// RGB444 pixels into a linear frame buffer at address y*H_RES + x.
//
// Ports
//   clk         camera pixel clock, rising edge
//   reset       asynchronous active-low reset
//   capture_en  arms capture; only looked at between frames
//   vsync       high between frames
//   href        high while a line's bytes are on cam_data
//   cam_data    camera byte, RGB565 high byte first
//   we          one-cycle frame-buffer write strobe
//   wAddr       frame-buffer address
//   wData       RGB444 pixel {R,G,B}
//   frame_done  one-cycle pulse when a captured frame ends
//   busy        high while a frame is being captured
//   line_err    sticky overrun flag, cleared at the next frame start
// ---------------------------------------------------------------------------
module qvga_capture
   import qvga_pkg::*;
#(
   parameter int H_RES = H_RES_DEF,
   parameter int V_RES = V_RES_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              capture_en,
   input  logic              vsync,
   input  logic              href,
   input  logic [7:0]        cam_data,
   output logic              we,
   output logic [ADDR_W-1:0] wAddr,
   output logic [11:0]       wData,
   output logic              frame_done,
   output logic              busy,
   output logic              line_err
);

   // Counters are one value wider than the active range so they can park at
   // H_RES / V_RES, which is what flags an overrun.
   localparam int X_W = $clog2(H_RES + 1);
   localparam int Y_W = $clog2(V_RES + 1);
   localparam logic [X_W-1:0]    X_LIM  = X_W'(H_RES);
   localparam logic [Y_W-1:0]    Y_LIM  = Y_W'(V_RES);
   localparam logic [X_W-1:0]    X_ONE  = X_W'(1);
   localparam logic [Y_W-1:0]    Y_ONE  = Y_W'(1);
   localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(H_RES);

   qvga_state_e       state_q, state_d;
   logic              vs_q, href_q;
   logic [X_W-1:0]    x_q, x_d;
   logic [Y_W-1:0]    y_q, y_d;
   logic              err_q, err_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] waddr_q, waddr_d;
   logic [11:0]       wdata_q, wdata_d;
   logic              fd_q, fd_d;
   logic              busy_q, busy_d;

   logic              vs_rise, vs_fall, href_fall;
   logic              byte_en, clr;
   logic              pix_valid;
   logic [11:0]       pix;

   assign vs_rise   = ~vs_q & vsync;
   assign vs_fall   = vs_q & ~vsync;
   assign href_fall = href_q & ~href;

   // A byte arriving in the same cycle the frame ends is dropped, so a write
   // strobe can never trail out of ACTIVE.
   assign byte_en = (state_q == ACTIVE) & href & ~vs_rise;
   assign clr     = ((state_q == WAIT_VS) & vs_fall) |
                    ((state_q == ACTIVE) & ~vs_rise & href_fall);

   rgb565_to_444 u_conv (
      .clk       (clk),
      .reset     (reset),
      .clr       (clr),
      .byte_en   (byte_en),
      .cam_data  (cam_data),
      .pix_valid (pix_valid),
      .pix       (pix)
   );

   // Capture FSM, pixel counters and write-port next-state logic.
   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      err_d   = err_q;
      we_d    = 1'b0;
      waddr_d = waddr_q;
      wdata_d = wdata_q;
      fd_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (capture_en) begin
               state_d = WAIT_VS;
            end else begin
               state_d = IDLE;
            end
         end
         WAIT_VS: begin
            if (vs_fall) begin
               state_d = ACTIVE;
               x_d     = '0;
               y_d     = '0;
               err_d   = 1'b0;
            end else begin
               state_d = WAIT_VS;
            end
         end
         ACTIVE: begin
            if (vs_rise) begin
               state_d = capture_en ? WAIT_VS : IDLE;
               fd_d    = 1'b1;
            end else if (href_fall) begin
               // An href pulse that produced no pixel is not a line.
               if (x_q != '0) begin
                  x_d = '0;
                  y_d = (y_q < Y_LIM) ? (y_q + Y_ONE) : y_q;
               end else begin
                  x_d = x_q;
               end
            end else if (pix_valid) begin
               if ((x_q < X_LIM) && (y_q < Y_LIM)) begin
                  we_d    = 1'b1;
                  waddr_d = (ADDR_W'(y_q) * STRIDE) + ADDR_W'(x_q);
                  wdata_d = pix;
               end else begin
                  err_d = 1'b1;
               end
               x_d = (x_q < X_LIM) ? (x_q + X_ONE) : x_q;
            end else begin
               state_d = ACTIVE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      busy_d = (state_d == ACTIVE);
   end

   // State, edge-detect, counter and output registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         vs_q    <= 1'b0;
         href_q  <= 1'b0;
         x_q     <= '0;
         y_q     <= '0;
         err_q   <= 1'b0;
         we_q    <= 1'b0;
         waddr_q <= '0;
         wdata_q <= 12'd0;
         fd_q    <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         vs_q    <= vsync;
         href_q  <= href;
         x_q     <= x_d;
         y_q     <= y_d;
         err_q   <= err_d;
         we_q    <= we_d;
         waddr_q <= waddr_d;
         wdata_q <= wdata_d;
         fd_q    <= fd_d;
         busy_q  <= busy_d;
      end
   end

   assign we         = we_q;
   assign wAddr      = waddr_q;
   assign wData      = wdata_q;
   assign frame_done = fd_q;
   assign busy       = busy_q;
   assign line_err   = err_q;

endmodule

// File: tb/tb_qvga_capture.sv
// ---------------------------------------------------------------------------
// tb_qvga_capture
// Self-checking bench for qvga_capture at the default 320x240 geometry.
// Expected frame-buffer writes are queued as bytes are driven and matched
// against every write strobe the design produces.
// ---------------------------------------------------------------------------
module tb_qvga_capture;

   logic        clk = 1'b0;
   logic        reset;
   logic        capture_en;
   logic        vsync;
   logic        href;
   logic [7:0]  cam_data;
   logic        we;
   logic [16:0] wAddr;
   logic [11:0] wData;
   logic        frame_done;
   logic        busy;
   logic        line_err;

   int          checks   = 0;
   int          errors   = 0;
   logic [28:0] exp_q[$];
   int          n_writes = 0;
   logic [16:0] last_addr = 17'd0;
   int          fd_count = 0;
   logic        fd_prev  = 1'b0;
   int          mx = 0;
   int          my = 0;

   qvga_capture dut (
      .clk        (clk),
      .reset      (reset),
      .capture_en (capture_en),
      .vsync      (vsync),
      .href       (href),
      .cam_data   (cam_data),
      .we         (we),
      .wAddr      (wAddr),
      .wData      (wData),
      .frame_done (frame_done),
      .busy       (busy),
      .line_err   (line_err)
   );

   always #5 clk = ~clk;

   // Write-port monitor: every strobe must match the oldest expected write.
   always @(negedge clk) begin
      logic [28:0] e;
      if (we === 1'b1) begin
         n_writes++;
         last_addr = wAddr;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write: got wAddr=%0d wData=%h, expected no write", wAddr, wData);
         end else begin
            e = exp_q.pop_front();
            if ({wAddr, wData} !== e) begin
               errors++;
               $display("FAIL write_data: got wAddr=%0d wData=%h, expected wAddr=%0d wData=%h",
                        wAddr, wData, e[28:12], e[11:0]);
            end
         end
         checks++;
         if (busy !== 1'b1) begin
            errors++;
            $display("FAIL we_outside_active: got busy=%b with we=1, expected busy=1", busy);
         end
      end
      if (frame_done === 1'b1) begin
         fd_count++;
         checks++;
         if (fd_prev === 1'b1) begin
            errors++;
            $display("FAIL frame_done_width: got frame_done high 2 cycles, expected 1");
         end
      end
      fd_prev = frame_done;
   end

   // Watchdog so the run always ends.
   initial begin
      #500000;
      $display("FAIL watchdog: got no end of test, expected completion");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic frame_start();
      vsync = 1'b1;
      repeat (3) tick();
      vsync = 1'b0;
      tick();
      tick();
      mx = 0;
      my = 0;
   endtask

   task automatic frame_end();
      vsync = 1'b1;
      repeat (3) tick();
   endtask

   // Drives one href line of nbytes bytes; queues the writes it should cause.
   task automatic send_line(input int nbytes, input logic [7:0] hi, input logic [7:0] lo,
                            input logic [11:0] pix, input bit expect_on);
      for (int i = 0; i < nbytes; i++) begin
         href     = 1'b1;
         cam_data = (i % 2 == 0) ? hi : lo;
         if (i % 2 == 1) begin
            if (expect_on && mx < 320 && my < 240)
               exp_q.push_back({17'(my * 320 + mx), pix});
            mx++;
         end
         tick();
      end
      href     = 1'b0;
      cam_data = 8'h00;
      if (mx > 0) begin
         mx = 0;
         my++;
      end
      tick();
      tick();
   endtask

   task automatic test_reset();
      reset      = 1'b0;
      capture_en = 1'b0;
      vsync      = 1'b1;
      href       = 1'b0;
      cam_data   = 8'h00;
      repeat (3) tick();
      checks++;
      if ({we, wAddr, wData, frame_done, busy, line_err} !== 33'd0) begin
         errors++;
         $display("FAIL reset_outputs: got we=%b wAddr=%0d wData=%h fd=%b busy=%b err=%b, expected all 0",
                  we, wAddr, wData, frame_done, busy, line_err);
      end
      reset = 1'b1;
      repeat (3) tick();
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL idle_busy: got busy=%b, expected 0", busy);
      end
   endtask

   task automatic test_pixel_pair();
      int fd0;
      fd0 = fd_count;
      capture_en = 1'b1;
      tick();
      tick();
      frame_start();
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL active_busy: got busy=%b, expected 1", busy);
      end
      href     = 1'b1;
      cam_data = 8'h07;
      tick();
      checks++;
      if (we !== 1'b0) begin
         errors++;
         $display("FAIL first_byte_we: got we=%b, expected 0", we);
      end
      cam_data = 8'hE0;
      exp_q.push_back({17'd0, 12'h0F0});
      tick();
      checks++;
      if (we !== 1'b1 || wAddr !== 17'd0 || wData !== 12'h0F0) begin
         errors++;
         $display("FAIL pixel_pair: got we=%b wAddr=%0d wData=%h, expected we=1 wAddr=0 wData=0f0",
                  we, wAddr, wData);
      end
      href     = 1'b0;
      cam_data = 8'h00;
      tick();
      checks++;
      if (we !== 1'b0) begin
         errors++;
         $display("FAIL we_one_cycle: got we=%b, expected 0", we);
      end
      tick();
      frame_end();
      checks++;
      if (fd_count != fd0 + 1) begin
         errors++;
         $display("FAIL pair_frame_done: got %0d pulses, expected 1", fd_count - fd0);
      end
   endtask

   task automatic test_full_frame();
      int fd0;
      int w0;
      fd0 = fd_count;
      w0  = n_writes;
      frame_start();
      for (int y = 0; y < 239; y++)
         send_line(2, 8'hF8, 8'h00, 12'hF00, 1'b1);
      send_line(640, 8'hF8, 8'h00, 12'hF00, 1'b1);
      checks++;
      if (last_addr !== 17'd76799 || n_writes - w0 != 559) begin
         errors++;
         $display("FAIL last_line: got last wAddr=%0d writes=%0d, expected 76799 and 559",
                  last_addr, n_writes - w0);
      end
      checks++;
      if (line_err !== 1'b0) begin
         errors++;
         $display("FAIL frame_no_err: got line_err=%b, expected 0", line_err);
      end
      send_line(2, 8'hF8, 8'h00, 12'hF00, 1'b1);
      checks++;
      if (line_err !== 1'b1 || n_writes - w0 != 559) begin
         errors++;
         $display("FAIL y_overrun: got line_err=%b writes=%0d, expected 1 and 559", line_err, n_writes - w0);
      end
      frame_end();
      checks++;
      if (fd_count != fd0 + 1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL full_frame_done: got pulses=%0d busy=%b, expected 1 and 0", fd_count - fd0, busy);
      end
   endtask

   task automatic test_line_overrun();
      int w0;
      frame_start();
      checks++;
      if (line_err !== 1'b0) begin
         errors++;
         $display("FAIL err_cleared: got line_err=%b at frame start, expected 0", line_err);
      end
      w0 = n_writes;
      for (int y = 0; y < 5; y++)
         send_line(2, 8'h07, 8'hE0, 12'h0F0, 1'b1);
      send_line(644, 8'hF8, 8'h00, 12'hF00, 1'b1);
      checks++;
      if (last_addr !== 17'd1919 || n_writes - w0 != 325 || line_err !== 1'b1) begin
         errors++;
         $display("FAIL x_overrun: got last wAddr=%0d writes=%0d err=%b, expected 1919 325 1",
                  last_addr, n_writes - w0, line_err);
      end
      frame_end();
   endtask

   task automatic test_odd_bytes();
      int w0;
      frame_start();
      w0 = n_writes;
      send_line(641, 8'hF8, 8'h00, 12'hF00, 1'b1);
      checks++;
      if (n_writes - w0 != 320 || line_err !== 1'b0 || last_addr !== 17'd319) begin
         errors++;
         $display("FAIL odd_line: got writes=%0d err=%b last=%0d, expected 320 0 319",
                  n_writes - w0, line_err, last_addr);
      end
      send_line(1, 8'hF8, 8'h00, 12'hF00, 1'b1);
      send_line(2, 8'h07, 8'hE0, 12'h0F0, 1'b1);
      checks++;
      if (last_addr !== 17'd320 || n_writes - w0 != 321) begin
         errors++;
         $display("FAIL next_line_x0: got last wAddr=%0d writes=%0d, expected 320 and 321",
                  last_addr, n_writes - w0);
      end
      frame_end();
   endtask

   task automatic test_capture_en_drop();
      int fd0;
      int w0;
      fd0 = fd_count;
      frame_start();
      for (int y = 0; y < 100; y++)
         send_line(2, 8'hF8, 8'h00, 12'hF00, 1'b1);
      capture_en = 1'b0;
      w0 = n_writes;
      for (int y = 0; y < 3; y++)
         send_line(2, 8'hF8, 8'h00, 12'hF00, 1'b1);
      checks++;
      if (n_writes - w0 != 3 || last_addr !== 17'd32640) begin
         errors++;
         $display("FAIL en_drop_writes: got writes=%0d last=%0d, expected 3 and 32640",
                  n_writes - w0, last_addr);
      end
      frame_end();
      checks++;
      if (fd_count != fd0 + 1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL en_drop_done: got pulses=%0d busy=%b, expected 1 and 0", fd_count - fd0, busy);
      end
      w0 = n_writes;
      frame_start();
      send_line(4, 8'hF8, 8'h00, 12'hF00, 1'b0);
      checks++;
      if (n_writes != w0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL idle_frame: got writes=%0d busy=%b, expected 0 and 0", n_writes - w0, busy);
      end
      frame_end();
      checks++;
      if (fd_count != fd0 + 1) begin
         errors++;
         $display("FAIL idle_frame_done: got pulses=%0d, expected 1", fd_count - fd0);
      end
   endtask

   task automatic test_reset_midframe();
      int fd0;
      int w0;
      capture_en = 1'b1;
      tick();
      tick();
      frame_start();
      for (int y = 0; y < 50; y++)
         send_line(2, 8'h07, 8'hE0, 12'h0F0, 1'b1);
      fd0 = fd_count;
      reset = 1'b0;
      #1;
      checks++;
      if ({we, wAddr, wData, frame_done, busy, line_err} !== 33'd0) begin
         errors++;
         $display("FAIL midframe_reset: got we=%b wAddr=%0d wData=%h fd=%b busy=%b err=%b, expected all 0",
                  we, wAddr, wData, frame_done, busy, line_err);
      end
      tick();
      reset = 1'b1;
      tick();
      tick();
      w0 = n_writes;
      send_line(4, 8'hF8, 8'h00, 12'hF00, 1'b0);
      checks++;
      if (n_writes != w0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL resume_wait: got writes=%0d busy=%b, expected 0 and 0", n_writes - w0, busy);
      end
      frame_end();
      checks++;
      if (fd_count != fd0) begin
         errors++;
         $display("FAIL abandoned_done: got %0d pulses, expected 0", fd_count - fd0);
      end
      frame_start();
      send_line(2, 8'h07, 8'hE0, 12'h0F0, 1'b1);
      checks++;
      if (last_addr !== 17'd0 || n_writes != w0 + 1) begin
         errors++;
         $display("FAIL restart_addr: got last wAddr=%0d writes=%0d, expected 0 and 1",
                  last_addr, n_writes - w0);
      end
      frame_end();
      checks++;
      if (fd_count != fd0 + 1) begin
         errors++;
         $display("FAIL restart_done: got %0d pulses, expected 1", fd_count - fd0);
      end
   endtask

   initial begin
      test_reset();
      test_pixel_pair();
      test_full_frame();
      test_line_overrun();
      test_odd_bytes();
      test_capture_en_drop();
      test_reset_midframe();
      tick();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL missing_writes: got %0d expected writes never seen, expected 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/qvga_capture.md
QVGA_CAPTURE -- requirements
Module: qvga_capture

Interface
REQ-001 SHALL have parameter H_RES, default 320, active pixels per line.
REQ-002 SHALL have parameter V_RES, default 240, active lines per frame.
REQ-003 SHALL have port clk  input  1  camera pixel clock; the only clock, all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port capture_en  input  1  arms capture; sampled only at frame boundaries.
REQ-006 SHALL have port vsync  input  1  camera vertical sync, high between frames.
REQ-007 SHALL have port href  input  1  camera line-valid, high during active bytes.
REQ-008 SHALL have port cam_data  input  8  camera byte, RGB565 high byte first.
REQ-009 SHALL have port we  output  1  one-cycle frame-buffer write strobe.
REQ-010 SHALL have port wAddr  output  17  frame-buffer address, y*H_RES+x.
REQ-011 SHALL have port wData  output  12  RGB444 pixel {R[3:0],G[3:0],B[3:0]}.
REQ-012 SHALL have port frame_done  output  1  one-cycle pulse at end of a captured frame.
REQ-013 SHALL have port busy  output  1  high while a frame is being captured.
REQ-014 SHALL have port line_err  output  1  sticky overrun flag, cleared at next frame start.

Function
REQ-015 SHALL implement states IDLE, WAIT_VS, ACTIVE.
REQ-016 SHALL move IDLE->WAIT_VS when capture_en=1.
REQ-017 SHALL move WAIT_VS->ACTIVE on vsync falling edge (registered vsync 1->0), clearing x, y, byte phase and line_err.
REQ-018 SHALL move ACTIVE->WAIT_VS on vsync rising edge if capture_en=1, else ACTIVE->IDLE, pulsing frame_done for exactly one cycle in that transition.
REQ-019 SHALL ignore capture_en deassertion mid-frame; the current frame completes.
REQ-020 SHALL in ACTIVE with href=1 toggle byte phase every cycle: phase 0 latches cam_data as high byte, phase 1 forms the pixel.
REQ-021 SHALL map RGB565 {hi,lo} to wData = {hi[7:4], hi[2:0]&lo[7], lo[4:1]}, i.e. R[4:1], G[5:2], B[4:1].
REQ-022 SHALL assert we, wData and wAddr registered, one cycle after the phase-1 byte is sampled.
REQ-023 SHALL increment x after each pixel; wAddr = y*H_RES + x computed with 17-bit width, no overflow for x<H_RES, y<V_RES.
REQ-024 SHALL on href falling edge with x>0 reset x and phase to 0 and increment y; href pulses with x=0 do not advance y.
REQ-025 SHALL suppress we and set line_err when x reaches H_RES and more pixels arrive on the same line.
REQ-026 SHALL suppress we and set line_err for any pixel when y >= V_RES.
REQ-027 SHALL discard an odd trailing byte at href falling (phase reset, no write).
REQ-028 SHALL drive busy=1 exactly in ACTIVE.
REQ-029 SHALL never assert we outside ACTIVE.

Reset
REQ-030 SHALL on reset low enter IDLE with we=0, wAddr=0, wData=0, frame_done=0, busy=0, line_err=0, x=y=phase=0, edge-detect registers=0.
REQ-031 SHALL on reset mid-frame abandon the frame without frame_done; after release, capture resumes only at the next vsync falling edge.

Structure
REQ-032 SHALL take H_RES/V_RES defaults, address width 17 and the state enum from shared package qvga_pkg.
REQ-033 SHALL isolate the RGB565->RGB444 byte assembly in one sub-module rgb565_to_444 (combinational conversion plus phase register).

Verification
REQ-034 SHALL cover: capture_en=1, one frame 320x240 of pixel {8'hF8,8'h00} -> 76800 writes, wData=12'hF00, last wAddr=76799, one frame_done.
REQ-035 SHALL cover: line of 322 pixels on y=5 -> writes wAddr 1600..1919 only, line_err=1, no write to 1920.
REQ-036 SHALL cover: byte pair {8'h07,8'hE0} at x=0,y=0 -> we one cycle after 2nd byte, wAddr=0, wData=12'h0F0.
REQ-037 SHALL cover: capture_en dropped at y=100 -> frame completes, frame_done pulses, state IDLE, no writes on next frame.
REQ-038 SHALL cover: reset low at y=50 -> all outputs 0 immediately, no frame_done; next frame starts writes at wAddr=0.
REQ-039 SHALL cover: odd byte count (641 bytes) on a line -> 320 writes, 641st byte dropped, next line starts at x=0.
